// File: rtl/pipelined_adder.sv
// pipelined_adder
//   WIDTH-bit add/subtract split into STAGE_W-bit ripple slices. There is one
//   register stage per slice, so the latency is STAGES = WIDTH/STAGE_W cycles.
//   The design accepts one beat per cycle when it is not stalled.
//   WIDTH must be a multiple of STAGE_W.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active high
//   in_valid   operand beat present
//   in_ready   beat accepted this cycle (global pipeline enable)
//   a, b       operands
//   cin        carry in (ignored when sub=1)
//   sub        0: a+b+cin, 1: a-b
//   out_valid  result beat present
//   out_ready  downstream accepts result
//   sum        result, modulo 2^WIDTH
//   cout       carry out of MSB (for sub: 1 = no borrow)
//   ovf        signed two's-complement overflow
module pipelined_adder #(
  parameter int WIDTH   = 16,
  parameter int STAGE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / STAGE_W;

  // A single enable freezes the whole pipe when the output is held.
  // This keeps the control path trivial, and no beat can be dropped or
  // duplicated.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * STAGE_W;     // result bits resolved before this stage
    localparam int REM = WIDTH - LO;      // operand bits still to be consumed
    localparam int HI  = LO + STAGE_W;    // result bits resolved after this stage

    logic [REM-1:0]     a_in;
    logic [REM-1:0]     b_in;
    logic               c_in;
    logic               v_in;
    logic [STAGE_W:0]   slice;
    logic [HI-1:0]      res_d;
    logic [HI-1:0]      res_q;
    logic               carry_q;
    logic               valid_q;

    if (k == 0) begin : g_src
      // b is inverted once at entry. The upper slices therefore already
      // hold the effective operand, so the sub bit does not travel down the pipe.
      assign a_in  = a;
      assign b_in  = b ^ {WIDTH{sub}};
      assign c_in  = sub | cin;
      assign v_in  = in_valid;
      assign res_d = slice[STAGE_W-1:0];
    end else begin : g_src
      assign a_in  = g_stage[k-1].g_ops.a_q;
      assign b_in  = g_stage[k-1].g_ops.b_q;
      assign c_in  = g_stage[k-1].carry_q;
      assign v_in  = g_stage[k-1].valid_q;
      assign res_d = {slice[STAGE_W-1:0], g_stage[k-1].res_q};
    end

    assign slice = {1'b0, a_in[STAGE_W-1:0]} + {1'b0, b_in[STAGE_W-1:0]}
                 + {{STAGE_W{1'b0}}, c_in};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
      end else if (en) begin
        valid_q <= v_in;
      end
    end

    if (k < STAGES - 1) begin : g_ops
      // The operand slices that are not yet used are shifted down, so the
      // next stage always works on the low STAGE_W bits.
      logic [REM-STAGE_W-1:0] a_q;
      logic [REM-STAGE_W-1:0] b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q     <= '0;
          b_q     <= '0;
          res_q   <= '0;
          carry_q <= 1'b0;
        end else if (en) begin
          a_q     <= a_in[REM-1:STAGE_W];
          b_q     <= b_in[REM-1:STAGE_W];
          res_q   <= res_d;
          carry_q <= slice[STAGE_W];
        end
      end
    end else begin : g_last
      // The output registers load only on a real beat. Bubbles advance the
      // valid bit, but sum/cout/ovf keep the last result.
      logic ovf_d;
      logic ovf_q;

      assign ovf_d = (a_in[STAGE_W-1] == b_in[STAGE_W-1])
                  && (slice[STAGE_W-1] != a_in[STAGE_W-1]);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          res_q   <= '0;
          carry_q <= 1'b0;
          ovf_q   <= 1'b0;
        end else if (en && v_in) begin
          res_q   <= res_d;
          carry_q <= slice[STAGE_W];
          ovf_q   <= ovf_d;
        end
      end

      assign sum       = res_q;
      assign cout      = carry_q;
      assign ovf       = ovf_q;
      assign out_valid = valid_q;
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // main DUT, 16/4
  logic        in_valid, in_ready, out_valid, out_ready, cin, sub, cout, ovf;
  logic [15:0] a, b, sum;

  pipelined_adder #(.WIDTH(16), .STAGE_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf));

  // parameter sweep instances share one stimulus stream
  logic        sw_valid, sw_cin, sw_sub, sw_ordy;
  logic [7:0]  a8, b8;
  logic [31:0] a32, b32;
  logic        r88, v88, c88, o88, r82, v82, c82, o82, r324, v324, c324, o324;
  logic [7:0]  s88, s82;
  logic [31:0] s324;

  pipelined_adder #(.WIDTH(8), .STAGE_W(8)) dut8_8 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r88),
    .a(a8), .b(b8), .cin(sw_cin), .sub(sw_sub),
    .out_valid(v88), .out_ready(sw_ordy), .sum(s88), .cout(c88), .ovf(o88));

  pipelined_adder #(.WIDTH(8), .STAGE_W(2)) dut8_2 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r82),
    .a(a8), .b(b8), .cin(sw_cin), .sub(sw_sub),
    .out_valid(v82), .out_ready(sw_ordy), .sum(s82), .cout(c82), .ovf(o82));

  pipelined_adder #(.WIDTH(32), .STAGE_W(4)) dut32_4 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r324),
    .a(a32), .b(b32), .cin(sw_cin), .sub(sw_sub),
    .out_valid(v324), .out_ready(sw_ordy), .sum(s324), .cout(c324), .ovf(o324));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model built from plain integer arithmetic: {ovf, cout, sum}
  function automatic logic [65:0] ref_add(input int w, input logic [63:0] av,
                                          input logic [63:0] bv, input logic ci,
                                          input logic sb);
    longint unsigned mask, full;
    longint sa, sbv, s, lim;
    logic co, ov;
    mask = (64'd1 << w) - 64'd1;
    if (sb) begin
      full = (av - bv) & mask;
      co   = (av >= bv);
    end else begin
      full = av + bv + {63'd0, ci};
      co   = ((full >> w) & 64'd1) != 64'd0;
      full = full & mask;
    end
    sa  = longint'(av);
    sbv = longint'(bv);
    if (av[w-1]) sa  = sa  - (longint'(1) << w);
    if (bv[w-1]) sbv = sbv - (longint'(1) << w);
    s   = sb ? (sa - sbv) : (sa + sbv + longint'(ci));
    lim = longint'(1) << (w - 1);
    ov  = (s >= lim) || (s < -lim);
    return {ov, co, full[63:0]};
  endfunction

  task automatic run_vec(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic ci, input logic sb, input logic [15:0] es,
                         input logic ec, input logic eo);
    int lat;
    @(negedge clk);
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'd4);
    chk({tag, " sum"}, 64'(sum), 64'(es));
    chk({tag, " cout"}, 64'(cout), 64'(ec));
    chk({tag, " ovf"}, 64'(ovf), 64'(eo));
  endtask

  logic [15:0] va [32];
  logic [15:0] vb [32];
  logic        vc [32];
  logic        vs [32];
  logic [65:0] e8  [1000];
  logic [65:0] e32 [1000];

  initial begin
    int sent, rcv, cyc, extra;
    logic stall, hc, ho;
    logic [15:0] hs;
    logic [65:0] r;
    logic ev;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    sw_valid = 1'b0; sw_cin = 1'b0; sw_sub = 1'b0; sw_ordy = 1'b1;
    a8 = '0; b8 = '0; a32 = '0; b32 = '0;

    repeat (2) @(negedge clk);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst sum", 64'(sum), 64'd0);
    rst = 1'b0;
    #1;
    chk("post-rst in_ready", 64'(in_ready), 64'd1);
    chk("post-rst out_valid", 64'(out_valid), 64'd0);
    chk("post-rst cout", 64'(cout), 64'd0);
    chk("post-rst ovf", 64'(ovf), 64'd0);

    // directed vectors, hand-computed
    run_vec("add1234", 16'h1234, 16'h0FCD, 1'b1, 1'b0, 16'h2202, 1'b0, 1'b0);
    run_vec("carryall", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_vec("posovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_vec("sub5m7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_vec("subovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // bubbles with zero operands must not disturb the held outputs
    repeat (4) @(negedge clk);
    chk("hold valid", 64'(out_valid), 64'd0);
    chk("hold sum", 64'(sum), 64'h7FFF);
    chk("hold cout", 64'(cout), 64'd1);
    chk("hold ovf", 64'(ovf), 64'd1);

    // streaming with random backpressure
    for (int i = 0; i < 32; i++) begin
      va[i] = 16'($urandom);
      vb[i] = 16'($urandom);
      vc[i] = 1'($urandom_range(0, 1));
      vs[i] = 1'($urandom_range(0, 1));
    end
    sent = 0; rcv = 0; cyc = 0; stall = 1'b0; hs = '0; hc = 1'b0; ho = 1'b0;
    while (rcv < 32 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (stall) begin
        chk("stall valid", 64'(out_valid), 64'd1);
        chk("stall sum", 64'(sum), 64'(hs));
        chk("stall cout", 64'(cout), 64'(hc));
        chk("stall ovf", 64'(ovf), 64'(ho));
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (sent < 32) begin
        in_valid = 1'b1; a = va[sent]; b = vb[sent]; cin = vc[sent]; sub = vs[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        r = ref_add(16, {48'd0, va[rcv]}, {48'd0, vb[rcv]}, vc[rcv], vs[rcv]);
        chk("stream sum", 64'(sum), r[63:0]);
        chk("stream cout", 64'(cout), 64'(r[64]));
        chk("stream ovf", 64'(ovf), 64'(r[65]));
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      stall = out_valid && !out_ready;
      hs = sum; hc = cout; ho = ovf;
    end
    chk("stream count", 64'(rcv), 64'd32);
    in_valid = 1'b0; out_ready = 1'b1;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("stream extra beats", 64'(extra), 64'd0);

    // reset in the middle of operation
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre-rst valid", 64'(out_valid), 64'd1);
    chk("pre-rst sum", 64'(sum), 64'h3333);
    rst = 1'b1;
    #1;
    chk("midrst valid", 64'(out_valid), 64'd0);
    chk("midrst sum", 64'(sum), 64'd0);
    chk("midrst cout", 64'(cout), 64'd0);
    chk("midrst ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec("after rst", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);

    // parameter sweep: latencies 1, 4, 8
    for (int t = 0; t < 1008; t++) begin
      @(negedge clk);
      ev = (t >= 1) && (t - 1 < 1000);
      chk("w8s8 valid", 64'(v88), 64'(ev));
      if (ev) begin
        chk("w8s8 sum", 64'(s88), 64'(e8[t-1][7:0]));
        chk("w8s8 cout", 64'(c88), 64'(e8[t-1][64]));
        chk("w8s8 ovf", 64'(o88), 64'(e8[t-1][65]));
      end
      ev = (t >= 4) && (t - 4 < 1000);
      chk("w8s2 valid", 64'(v82), 64'(ev));
      if (ev) begin
        chk("w8s2 sum", 64'(s82), 64'(e8[t-4][7:0]));
        chk("w8s2 cout", 64'(c82), 64'(e8[t-4][64]));
        chk("w8s2 ovf", 64'(o82), 64'(e8[t-4][65]));
      end
      ev = (t >= 8) && (t - 8 < 1000);
      chk("w32s4 valid", 64'(v324), 64'(ev));
      if (ev) begin
        chk("w32s4 sum", 64'(s324), 64'(e32[t-8][31:0]));
        chk("w32s4 cout", 64'(c324), 64'(e32[t-8][64]));
        chk("w32s4 ovf", 64'(o324), 64'(e32[t-8][65]));
      end
      if (t == 0) begin
        chk("sweep in_ready", 64'({r88, r82, r324}), 64'd7);
      end
      if (t < 1000) begin
        sw_valid = 1'b1;
        a8  = 8'($urandom);
        b8  = 8'($urandom);
        a32 = $urandom;
        b32 = $urandom;
        sw_cin = 1'($urandom_range(0, 1));
        sw_sub = 1'($urandom_range(0, 1));
        e8[t]  = ref_add(8,  {56'd0, a8},  {56'd0, b8},  sw_cin, sw_sub);
        e32[t] = ref_add(32, {32'd0, a32}, {32'd0, b32}, sw_cin, sw_sub);
      end else begin
        sw_valid = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
